// File: rtl/serial_pattern_sequencer_if.sv
// Command bus between the host/test driver and the pattern sequencer.
interface serial_pattern_sequencer_if #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned REP_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [SEL_W-1:0] cmd_sel;
  logic [REP_W-1:0] cmd_rep;

  modport master (output cmd_valid, output cmd_sel, output cmd_rep, input  cmd_ready);
  modport slave  (input  cmd_valid, input  cmd_sel, input  cmd_rep, output cmd_ready);
endinterface

// File: rtl/serial_pattern_sequencer.sv
// Thermometer-code serialiser sequencer: queues (level, repeat) commands in a
// small FIFO and scans one LSB-first frame of 2**SEL_W bits per repeat.
module serial_pattern_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned REP_W      = 4
) (
  input  logic                          clk,
  input  logic                          clear_n,
  input  logic                          en,
  serial_pattern_sequencer_if.slave     cmd,
  output logic                          ser_out,
  output logic                          ser_valid,
  output logic                          frame_start,
  output logic                          frame_last,
  output logic                          done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [SEL_W-1:0] LAST_BIT = {SEL_W{1'b1}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] fifo_sel [FIFO_DEPTH];
  logic [REP_W-1:0] fifo_rep [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [SEL_W-1:0] sel_q, sel_d, bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_q, rep_d, rep_cnt_q, rep_cnt_d;
  logic [CNT_W-1:0] count_d;
  logic             push, pop;
  logic             ser_out_d, ser_valid_d, frame_start_d, frame_last_d;
  logic             done_d, busy_d, ready_d;

  // cmd_ready is registered, so a full FIFO refuses a push even when it pops
  assign push = cmd.cmd_valid & cmd.cmd_ready;

  // Command storage; pointers live in the main register block
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_sel[wr_ptr_q] <= cmd.cmd_sel;
      fifo_rep[wr_ptr_q] <= cmd.cmd_rep;
    end
  end

  // Next-state, scan position and registered-output values
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    rep_d         = rep_q;
    bit_cnt_d     = bit_cnt_q;
    rep_cnt_d     = rep_cnt_q;
    pop           = 1'b0;
    ser_out_d     = ser_out;
    ser_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_last_d  = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en && (fifo_count != '0)) state_d = S_LOAD;
      end
      S_LOAD: begin
        pop       = 1'b1;
        sel_d     = fifo_sel[rd_ptr_q];
        rep_d     = fifo_rep[rd_ptr_q];
        bit_cnt_d = '0;
        rep_cnt_d = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        if (en) begin
          ser_out_d     = (bit_cnt_q <= sel_q);
          ser_valid_d   = 1'b1;
          frame_start_d = (bit_cnt_q == '0);
          frame_last_d  = (bit_cnt_q == LAST_BIT);
          bit_cnt_d     = bit_cnt_q + SEL_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            if (rep_cnt_q < rep_q) begin
              rep_cnt_d = rep_cnt_q + REP_W'(1);
            end else begin
              done_d  = 1'b1;
              state_d = ((fifo_count != '0) || push) ? S_LOAD : S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    count_d = fifo_count;
    if (push && !pop)      count_d = fifo_count + CNT_W'(1);
    else if (!push && pop) count_d = fifo_count - CNT_W'(1);

    ready_d = (count_d < CNT_W'(FIFO_DEPTH));
    busy_d  = (state_q != S_IDLE) || (fifo_count != '0);
  end

  // State, counters, FIFO pointers and all outputs; clear_n wipes everything
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state_q       <= S_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      sel_q         <= '0;
      rep_q         <= '0;
      bit_cnt_q     <= '0;
      rep_cnt_q     <= '0;
      fifo_count    <= '0;
      cmd.cmd_ready <= 1'b0;
      ser_out       <= 1'b0;
      ser_valid     <= 1'b0;
      frame_start   <= 1'b0;
      frame_last    <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      sel_q         <= sel_d;
      rep_q         <= rep_d;
      bit_cnt_q     <= bit_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      fifo_count    <= count_d;
      cmd.cmd_ready <= ready_d;
      ser_out       <= ser_out_d;
      ser_valid     <= ser_valid_d;
      frame_start   <= frame_start_d;
      frame_last    <= frame_last_d;
      done          <= done_d;
      busy          <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_pattern_sequencer.sv
// Directed bench for serial_pattern_sequencer.
module tb_serial_pattern_sequencer;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned SEL_W      = 3;
  localparam int unsigned REP_W      = 4;

  logic       clk = 1'b0;
  logic       clear_n = 1'b0;
  logic       en = 1'b1;
  logic       ser_out, ser_valid, frame_start, frame_last, done, busy;
  logic [2:0] fifo_count;

  int tests = 0;
  int fails = 0;

  // bit i of each vector = value sampled i+1 edges after capture starts
  logic [63:0] cap_v, cap_d, cap_s, cap_l, cap_dn, cap_b, cap_raw;

  serial_pattern_sequencer_if #(.SEL_W(SEL_W), .REP_W(REP_W)) cmd_if ();

  serial_pattern_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .SEL_W     (SEL_W),
    .REP_W     (REP_W)
  ) dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .en         (en),
    .cmd        (cmd_if.slave),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_start(frame_start),
    .frame_last (frame_last),
    .done       (done),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] sel, input logic [3:0] rep);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_sel   = sel;
    cmd_if.cmd_rep   = rep;
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Runs n cycles, dropping en for plen cycles starting at cycle p0
  task automatic capture(input int n, input int p0, input int plen);
    cap_v = '0; cap_d = '0; cap_s = '0; cap_l = '0; cap_dn = '0; cap_b = '0; cap_raw = '0;
    for (int i = 0; i < n; i++) begin
      en = !((i >= p0) && (i < p0 + plen));
      tick();
      cap_v[6'(i)]   = ser_valid;
      cap_d[6'(i)]   = ser_out & ser_valid;
      cap_raw[6'(i)] = ser_out;
      cap_s[6'(i)]   = frame_start;
      cap_l[6'(i)]   = frame_last;
      cap_dn[6'(i)]  = done;
      cap_b[6'(i)]   = busy;
    end
    en = 1'b1;
  endtask

  task automatic test_reset();
    logic [9:0] outs;
    clear_n = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_sel = '0;
    cmd_if.cmd_rep = '0;
    tick(); tick();
    outs = {ser_out, ser_valid, frame_start, frame_last, done, busy, cmd_if.cmd_ready, fifo_count};
    tests++;
    if (outs !== 10'h000) begin fails++; $display("FAIL reset_outputs got %h want 000", outs); end
    clear_n = 1'b1;
    tick();
    outs = {ser_out, ser_valid, frame_start, frame_last, done, busy, cmd_if.cmd_ready, fifo_count};
    tests++;
    if (outs !== 10'h008) begin fails++; $display("FAIL after_reset got %h want 008", outs); end
  endtask

  task automatic test_single_frame();
    push(3'd2, 4'd0);
    tests++;
    if (fifo_count !== 3'd1) begin fails++; $display("FAIL t1_count got %0d want 1", fifo_count); end
    capture(12, 12, 0);
    tests++;
    if (cap_v[11:0] !== 12'h3FC) begin fails++; $display("FAIL t1_valid got %h want 3fc", cap_v[11:0]); end
    tests++;
    if (cap_d[11:0] !== 12'h01C) begin fails++; $display("FAIL t1_data got %h want 01c", cap_d[11:0]); end
    tests++;
    if (cap_s[11:0] !== 12'h004) begin fails++; $display("FAIL t1_start got %h want 004", cap_s[11:0]); end
    tests++;
    if (cap_l[11:0] !== 12'h200) begin fails++; $display("FAIL t1_last got %h want 200", cap_l[11:0]); end
    tests++;
    if (cap_dn[11:0] !== 12'h200) begin fails++; $display("FAIL t1_done got %h want 200", cap_dn[11:0]); end
    tests++;
    if (cap_b[11:0] !== 12'h3FF) begin fails++; $display("FAIL t1_busy got %h want 3ff", cap_b[11:0]); end
  endtask

  task automatic test_repeat();
    push(3'd7, 4'd2);
    capture(28, 28, 0);
    tests++;
    if (cap_v[27:0] !== 28'h3FFFFFC) begin fails++; $display("FAIL t2_valid got %h want 3fffffc", cap_v[27:0]); end
    tests++;
    if (cap_d[27:0] !== 28'h3FFFFFC) begin fails++; $display("FAIL t2_data got %h want 3fffffc", cap_d[27:0]); end
    tests++;
    if (cap_s[27:0] !== 28'h0040404) begin fails++; $display("FAIL t2_start got %h want 0040404", cap_s[27:0]); end
    tests++;
    if (cap_l[27:0] !== 28'h2020200) begin fails++; $display("FAIL t2_last got %h want 2020200", cap_l[27:0]); end
    tests++;
    if (cap_dn[27:0] !== 28'h2000000) begin fails++; $display("FAIL t2_done got %h want 2000000", cap_dn[27:0]); end
  endtask

  task automatic test_fifo_full();
    int  acc;
    int  dn;
    int  ones;
    int  cyc;
    bit  popped;
    push(3'd7, 4'd15);
    tick(); tick(); tick();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_sel   = 3'(i + 1);
      cmd_if.cmd_rep   = 4'd0;
      if (cmd_if.cmd_ready === 1'b1) acc++;
      tick();
    end
    tests++;
    if (acc != 4) begin fails++; $display("FAIL t3_accepted got %0d want 4", acc); end
    tests++;
    if (fifo_count !== 3'd4) begin fails++; $display("FAIL t3_count_full got %0d want 4", fifo_count); end
    tests++;
    if (cmd_if.cmd_ready !== 1'b0) begin fails++; $display("FAIL t3_ready_full got %b want 0", cmd_if.cmd_ready); end
    // keep offering: the pop edge must not also take a push
    popped = 1'b0;
    for (int c = 0; c < 300 && !popped; c++) begin
      tick();
      if (fifo_count !== 3'd4) begin
        popped = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        tests++;
        if (fifo_count !== 3'd3) begin fails++; $display("FAIL t3_count_pop got %0d want 3", fifo_count); end
        tests++;
        if (cmd_if.cmd_ready !== 1'b1) begin fails++; $display("FAIL t3_ready_pop got %b want 1", cmd_if.cmd_ready); end
      end else begin
        tests++;
        if (cmd_if.cmd_ready !== 1'b0) begin fails++; $display("FAIL t3_ready_hold got %b want 0", cmd_if.cmd_ready); end
      end
    end
    cmd_if.cmd_valid = 1'b0;
    tests++;
    if (!popped) begin fails++; $display("FAIL t3_pop_timeout got no pop want pop"); end
    dn = 0; ones = 0; cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
      if (done === 1'b1) dn++;
      if ((ser_out & ser_valid) === 1'b1) ones++;
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL t3_drain_timeout got busy=%b want 0", busy); end
    tests++;
    if (dn != 4) begin fails++; $display("FAIL t3_done_count got %0d want 4", dn); end
    tests++;
    if (ones != 14) begin fails++; $display("FAIL t3_ones got %0d want 14", ones); end
  endtask

  task automatic test_back_to_back();
    push(3'd0, 4'd0);
    push(3'd1, 4'd0);
    capture(20, 20, 0);
    tests++;
    if (cap_v[19:0] !== 20'h3FDFE) begin fails++; $display("FAIL t4_valid got %h want 3fdfe", cap_v[19:0]); end
    tests++;
    if (cap_d[19:0] !== 20'h00C02) begin fails++; $display("FAIL t4_data got %h want 00c02", cap_d[19:0]); end
    tests++;
    if (cap_s[19:0] !== 20'h00402) begin fails++; $display("FAIL t4_start got %h want 00402", cap_s[19:0]); end
    tests++;
    if (cap_dn[19:0] !== 20'h20100) begin fails++; $display("FAIL t4_done got %h want 20100", cap_dn[19:0]); end
  endtask

  task automatic test_pause();
    push(3'd5, 4'd0);
    capture(14, 6, 3);
    tests++;
    if (cap_v[13:0] !== 14'h1E3C) begin fails++; $display("FAIL t5_valid got %h want 1e3c", cap_v[13:0]); end
    tests++;
    if (cap_d[13:0] !== 14'h063C) begin fails++; $display("FAIL t5_data got %h want 063c", cap_d[13:0]); end
    tests++;
    if (cap_raw[8:6] !== 3'b111) begin fails++; $display("FAIL t5_hold got %b want 111", cap_raw[8:6]); end
    tests++;
    if (cap_dn[13:0] !== 14'h1000) begin fails++; $display("FAIL t5_done got %h want 1000", cap_dn[13:0]); end
  endtask

  task automatic test_idle_no_pop();
    en = 1'b0;
    push(3'd4, 4'd0);
    tick(); tick(); tick(); tick();
    tests++;
    if ({fifo_count, busy, ser_valid} !== 5'b001_1_0) begin
      fails++; $display("FAIL t7_idle_hold got %b want 00110", {fifo_count, busy, ser_valid});
    end
    capture(12, 12, 0);
    tests++;
    if (cap_v[11:0] !== 12'h3FC) begin fails++; $display("FAIL t7_valid got %h want 3fc", cap_v[11:0]); end
    tests++;
    if (cap_d[11:0] !== 12'h07C) begin fails++; $display("FAIL t7_data got %h want 07c", cap_d[11:0]); end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] outs;
    int dn;
    int vl;
    push(3'd6, 4'd0);
    push(3'd2, 4'd0);
    push(3'd3, 4'd1);
    for (int i = 0; i < 6; i++) tick();
    tests++;
    if ({ser_valid, fifo_count} !== 4'b1_010) begin
      fails++; $display("FAIL t6_pre got %b want 1010", {ser_valid, fifo_count});
    end
    clear_n = 1'b0;
    tick();
    outs = {ser_out, ser_valid, frame_start, frame_last, done, busy, cmd_if.cmd_ready, fifo_count};
    tests++;
    if (outs !== 10'h000) begin fails++; $display("FAIL t6_in_reset got %h want 000", outs); end
    clear_n = 1'b1;
    tick();
    outs = {ser_out, ser_valid, frame_start, frame_last, done, busy, cmd_if.cmd_ready, fifo_count};
    tests++;
    if (outs !== 10'h008) begin fails++; $display("FAIL t6_release got %h want 008", outs); end
    dn = 0; vl = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) dn++;
      if (ser_valid === 1'b1) vl++;
    end
    tests++;
    if (dn != 0 || vl != 0) begin fails++; $display("FAIL t6_quiet got done=%0d valid=%0d want 0 0", dn, vl); end
    push(3'd3, 4'd0);
    capture(12, 12, 0);
    tests++;
    if (cap_v[11:0] !== 12'h3FC) begin fails++; $display("FAIL t6_valid got %h want 3fc", cap_v[11:0]); end
    tests++;
    if (cap_d[11:0] !== 12'h03C) begin fails++; $display("FAIL t6_data got %h want 03c", cap_d[11:0]); end
    tests++;
    if (cap_dn[11:0] !== 12'h200) begin fails++; $display("FAIL t6_done got %h want 200", cap_dn[11:0]); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_repeat();
    test_fifo_full();
    test_back_to_back();
    test_pause();
    test_idle_no_pop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
